// File: rtl/fp_mul_pkg.sv
// Shared definitions for the multiplier datapath: default widths, the beat
// record carried through the normaliser, and the pipeline-depth helper.
`timescale 1ns/1ps

package fp_mul_pkg;

    // Width of the full mantissa product and of the biased exponent
    localparam int MANT_PROD_W = 48;
    localparam int EXP_W       = 8;

    // Shift-amount width for the default datapath: covers 0..MANT_PROD_W
    localparam int MANT_SHAMT_W = $clog2(MANT_PROD_W) + 1;

    // One beat of the normaliser at the default datapath width
    typedef struct packed {
        logic                    valid;
        logic [MANT_PROD_W-1:0]  data;
        logic [MANT_SHAMT_W-1:0] shamt;
        logic [EXP_W-1:0]        exp;
        logic                    exp_ovf;
        logic                    sticky;
    } mant_beat_t;

    // Number of barrel stages needed to cover right shifts of 0..width-1
    function automatic int stage_count(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fp_norm_shift_stage.sv
// One barrel stage of the normaliser: conditionally shifts right by SHIFT
// (selected by bit log2(SHIFT) of the carried shift amount) and registers
// the beat with a hold enable shared by the whole pipeline.
// Optional sticky collection is built when FP_NORM_STICKY_EN is defined.
`timescale 1ns/1ps

module fp_norm_shift_stage #(
    parameter int WIDTH   = fp_mul_pkg::MANT_PROD_W,
    parameter int EXP_W   = fp_mul_pkg::EXP_W,
    parameter int SHAMT_W = $clog2(WIDTH) + 1,
    parameter int SHIFT   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [EXP_W-1:0]   in_exp,
    input  logic               in_exp_ovf,
`ifdef FP_NORM_STICKY_EN
    input  logic               in_sticky,
    output logic               out_sticky,
`endif
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic [EXP_W-1:0]   out_exp,
    output logic               out_exp_ovf
);

    // Shift-amount bit that selects this stage
    localparam int BIT = $clog2(SHIFT);

    logic             do_shift;
    logic [WIDTH-1:0] data_next;

    assign do_shift = in_shamt[BIT];

    // Conditional logical right shift, zeros enter from the MSB
    always_comb begin
        data_next = in_data;
        if (do_shift) begin
            data_next = in_data >> SHIFT;
        end
    end

`ifdef FP_NORM_STICKY_EN
    logic sticky_next;

    // Accumulate any ones that fall off the LSB end in this stage
    always_comb begin
        sticky_next = in_sticky | (do_shift & (|in_data[SHIFT-1:0]));
    end

    // Sticky register, frozen together with the rest of the stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sticky <= 1'b0;
        end else if (en) begin
            out_sticky <= sticky_next;
        end
    end
`endif

    // Stage register; holds everything, valid included, when not enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_shamt   <= '0;
            out_exp     <= '0;
            out_exp_ovf <= 1'b0;
        end else if (en) begin
            out_valid   <= in_valid;
            out_data    <= data_next;
            out_shamt   <= in_shamt;
            out_exp     <= in_exp;
            out_exp_ovf <= in_exp_ovf;
        end
    end

endmodule

// File: rtl/fp_norm_shift_pipe.sv
// Pipelined right-shift normaliser between the mantissa multiplier and the
// rounder. Variable shift 0..WIDTH, one barrel stage per register, exponent
// adjusted at entry, valid/ready handshake with whole-pipeline freeze.
// Optional feature macro: FP_NORM_STICKY_EN adds out_sticky and all sticky
// collection logic.
`timescale 1ns/1ps

module fp_norm_shift_pipe #(
    parameter  int WIDTH   = fp_mul_pkg::MANT_PROD_W,
    parameter  int EXP_W   = fp_mul_pkg::EXP_W,
    localparam int SHAMT_W = $clog2(WIDTH) + 1,
    localparam int STAGES  = fp_mul_pkg::stage_count(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [EXP_W-1:0]   in_exp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [EXP_W-1:0]   out_exp,
`ifdef FP_NORM_STICKY_EN
    output logic               out_sticky,
`endif
    output logic               out_exp_ovf
);

    // Per-boundary beat fields: index 0 is the entry, index k+1 is the
    // output register of stage k, index STAGES is the block output.
    logic               valid_s   [STAGES+1];
    logic [WIDTH-1:0]   data_s    [STAGES+1];
    logic [SHAMT_W-1:0] shamt_s   [STAGES+1];
    logic [EXP_W-1:0]   exp_s     [STAGES+1];
    logic               exp_ovf_s [STAGES+1];
`ifdef FP_NORM_STICKY_EN
    logic               sticky_s  [STAGES+1];
`endif

    logic               advance;
    logic               saturate;
    logic [WIDTH-1:0]   entry_data;
    logic [EXP_W:0]     exp_sum;

    // The whole pipeline moves when the output slot is empty or draining
    assign advance  = !valid_s[STAGES] || out_ready;
    assign in_ready = advance;

    // Entry conditioning: saturate oversized shifts and add the exponent
    always_comb begin
        saturate   = (in_shamt >= SHAMT_W'(WIDTH));
        entry_data = saturate ? '0 : in_data;
        exp_sum    = (EXP_W+1)'(in_exp) + (EXP_W+1)'(in_shamt);
    end

    assign valid_s[0]   = in_valid;
    assign data_s[0]    = entry_data;
    assign shamt_s[0]   = in_shamt;
    assign exp_s[0]     = exp_sum[EXP_W-1:0];
    assign exp_ovf_s[0] = exp_sum[EXP_W];
`ifdef FP_NORM_STICKY_EN
    // Every bit is lost on a saturated shift
    assign sticky_s[0]  = saturate & (|in_data);
`endif

    // Barrel stages: stage gi shifts by 2**gi
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        fp_norm_shift_stage #(
            .WIDTH   (WIDTH),
            .EXP_W   (EXP_W),
            .SHAMT_W (SHAMT_W),
            .SHIFT   (1 << gi)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .en          (advance),
            .in_valid    (valid_s[gi]),
            .in_data     (data_s[gi]),
            .in_shamt    (shamt_s[gi]),
            .in_exp      (exp_s[gi]),
            .in_exp_ovf  (exp_ovf_s[gi]),
`ifdef FP_NORM_STICKY_EN
            .in_sticky   (sticky_s[gi]),
            .out_sticky  (sticky_s[gi+1]),
`endif
            .out_valid   (valid_s[gi+1]),
            .out_data    (data_s[gi+1]),
            .out_shamt   (shamt_s[gi+1]),
            .out_exp     (exp_s[gi+1]),
            .out_exp_ovf (exp_ovf_s[gi+1])
        );
    end

    assign out_valid   = valid_s[STAGES];
    assign out_data    = data_s[STAGES];
    assign out_exp     = exp_s[STAGES];
    assign out_exp_ovf = exp_ovf_s[STAGES];
`ifdef FP_NORM_STICKY_EN
    assign out_sticky  = sticky_s[STAGES];
`endif

endmodule

// File: tb/tb_fp_norm_shift_pipe.sv
// Directed testbench for fp_norm_shift_pipe (WIDTH=48, EXP_W=8, 6 stages).
// Sticky checks are compiled in only when FP_NORM_STICKY_EN is defined.
`timescale 1ns/1ps

module tb_fp_norm_shift_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic [6:0]  in_shamt;
    logic [7:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_data;
    logic [7:0]  out_exp;
    logic        out_exp_ovf;
`ifdef FP_NORM_STICKY_EN
    logic        out_sticky;
`endif

    int checks = 0;
    int passes = 0;

    fp_norm_shift_pipe #(
        .WIDTH (48),
        .EXP_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_shamt    (in_shamt),
        .in_exp      (in_exp),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_exp     (out_exp),
`ifdef FP_NORM_STICKY_EN
        .out_sticky  (out_sticky),
`endif
        .out_exp_ovf (out_exp_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Send one beat, wait (bounded) for it, check latency and all fields
    task automatic run_vec(input string tag, input logic [47:0] d, input logic [6:0] s,
                           input logic [7:0] e, input logic [47:0] xd, input logic [7:0] xe,
                           input logic xo, input logic xs);
        int lat;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_exp   = e;
        #1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd6);
        chk({tag, "_data"}, 64'(out_data), 64'(xd));
        chk({tag, "_exp"}, 64'(out_exp), 64'(xe));
        chk({tag, "_ovf"}, 64'(out_exp_ovf), 64'(xo));
`ifdef FP_NORM_STICKY_EN
        chk({tag, "_sticky"}, 64'(out_sticky), 64'(xs));
`else
        if (xs === 1'bx) $display("note: %s sticky expectation unknown", tag);
`endif
        $display("vec %s: data=%h shamt=%0d exp=%h -> out=%h exp=%h ovf=%b lat=%0d",
                 tag, d, s, e, out_data, out_exp, out_exp_ovf, lat);
        @(posedge clk); #1;
    endtask

    initial begin
        int tx;
        int rx;
        int stale;
        logic stall;
        logic prev_stall;
        logic [47:0] prev_data;
        logic [7:0]  prev_exp;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_exp    = '0;
        out_ready = 1'b1;

        // Reset state
        #3;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;

        // Directed single beats
        run_vec("basic", 48'h8000_0000_0001, 7'd1, 8'd127, 48'h4000_0000_0000, 8'd128, 1'b0, 1'b1);
        run_vec("pass", 48'hFFFF_FFFF_FFFF, 7'd0, 8'h55, 48'hFFFF_FFFF_FFFF, 8'h55, 1'b0, 1'b0);
        run_vec("sat48", 48'h1, 7'd48, 8'd10, 48'h0, 8'd58, 1'b0, 1'b1);
        run_vec("sat63", 48'h1, 7'd63, 8'd200, 48'h0, 8'd7, 1'b1, 1'b1);
        run_vec("sat_zero", 48'h0, 7'd48, 8'd0, 48'h0, 8'd48, 1'b0, 1'b0);
        run_vec("exp_wrap", 48'hC, 7'd2, 8'hFF, 48'h3, 8'h01, 1'b1, 1'b0);
        run_vec("msb_only", 48'hFFFF_FFFF_FFFF, 7'd47, 8'h10, 48'h1, 8'h3F, 1'b0, 1'b1);
        run_vec("mixed13", 48'h1234_5678_9ABC, 7'd13, 8'd100, 48'h0000_91A2_B3C4, 8'd113, 1'b0, 1'b1);

        // Backpressure: 20 back-to-back beats, out_ready low at cycles 8-10 and 14-16
        tx = 0;
        rx = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_exp   = '0;
        for (int cyc = 0; cyc < 80 && rx < 20; cyc++) begin
            stall     = (cyc >= 8 && cyc <= 10) || (cyc >= 14 && cyc <= 16);
            out_ready = !stall;
            in_valid  = (tx < 20);
            in_data   = 48'(tx + 1) << 4;
            in_shamt  = 7'd4;
            in_exp    = 8'(tx);
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'(!stall));
            if (prev_stall) begin
                chk("bp_hold_valid", 64'(out_valid), 64'd1);
                chk("bp_hold_data", 64'(out_data), 64'(prev_data));
                chk("bp_hold_exp", 64'(out_exp), 64'(prev_exp));
            end
            if (out_valid && out_ready) begin
                chk("bp_data", 64'(out_data), 64'(rx + 1));
                chk("bp_exp", 64'(out_exp), 64'(rx + 4));
                $display("bp beat %0d: out=%h exp=%h", rx, out_data, out_exp);
                rx++;
            end
            if (in_valid && in_ready) tx++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_exp   = out_exp;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 64'(rx), 64'd20);
        repeat (3) @(posedge clk);
        #1;

        // Reset with 4 beats in flight (first one frozen at the output)
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 48'hABC0 + 48'(i);
            in_shamt = 7'd0;
            in_exp   = 8'h11;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_exp", 64'(out_exp), 64'd0);
        chk("rst_out_ovf", 64'(out_exp_ovf), 64'd0);
`ifdef FP_NORM_STICKY_EN
        chk("rst_out_sticky", 64'(out_sticky), 64'd0);
`endif
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        $display("reset asserted with beats in flight: out_valid=%b in_ready=%b", out_valid, in_ready);
        @(posedge clk); @(posedge clk); #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        chk("rst_no_stale", 64'(stale), 64'd0);
        run_vec("post_rst", 48'h0000_0000_0F00, 7'd8, 8'd1, 48'h0000_0000_000F, 8'd9, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
